// File: rtl/systolic_pkg.sv
// Shared definitions for the 3x3 systolic-array controller.
// Latency: n/a (types, constants and index helpers only).
// Backpressure: n/a.
package systolic_pkg;

    // Array dimension: the array is N x N.
    localparam int N = 3;

    // Width of the FEED-phase k index (counts 0..N-1).
    localparam int K_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Element index of M[row][col] in a row-major packed N x N matrix.
    function automatic int mat_idx(input int row, input int col);
        return row * N + col;
    endfunction

endpackage

// File: rtl/systolic_feeder.sv
// Holds the operands of the running job and muxes row/column k onto the array feeds.
// Latency: operands land one cycle after load; feeds follow k_idx combinationally.
// Backpressure: none; the controller decides when to load and when to feed.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  feed_en,
    input  logic [K_W-1:0]        k_idx,
    input  logic [9*DATA_W-1:0]   a_mat,
    input  logic [9*DATA_W-1:0]   b_mat,
    output logic [DATA_W-1:0]     a_row0,
    output logic [DATA_W-1:0]     a_row1,
    output logic [DATA_W-1:0]     a_row2,
    output logic [DATA_W-1:0]     b_col0,
    output logic [DATA_W-1:0]     b_col1,
    output logic [DATA_W-1:0]     b_col2
);

    logic [9*DATA_W-1:0] a_q, a_d;
    logic [9*DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0]   a_row_w [N];
    logic [DATA_W-1:0]   b_col_w [N];

    // Capture operands only at job acceptance so later input changes cannot disturb the job.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load) begin
            a_d = a_mat;
            b_d = b_mat;
        end
    end

    // Operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Column k of A to the rows, row k of B to the columns; zeros outside FEED.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_row_w[i] = '0;
            b_col_w[i] = '0;
        end
        if (feed_en && (int'(k_idx) < N)) begin
            for (int i = 0; i < N; i++) begin
                a_row_w[i] = a_q[DATA_W*mat_idx(i, int'(k_idx)) +: DATA_W];
                b_col_w[i] = b_q[DATA_W*mat_idx(int'(k_idx), i) +: DATA_W];
            end
        end
    end

    assign a_row0 = a_row_w[0];
    assign a_row1 = a_row_w[1];
    assign a_row2 = a_row_w[2];
    assign b_col0 = b_col_w[0];
    assign b_col1 = b_col_w[1];
    assign b_col2 = b_col_w[2];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequences one 3x3 matrix job through an external systolic array: clear, feed, drain, capture.
// Latency: 5+DRAIN_CYC cycles from start acceptance to the first res_valid cycle.
// Backpressure: start only accepted in IDLE; result held in DONE until res_ready.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 16,
    parameter int DRAIN_CYC = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [9*DATA_W-1:0]   a_mat,
    input  logic [9*DATA_W-1:0]   b_mat,
    output logic                  arr_rst_n,
    output logic [DATA_W-1:0]     a_row0,
    output logic [DATA_W-1:0]     a_row1,
    output logic [DATA_W-1:0]     a_row2,
    output logic [DATA_W-1:0]     b_col0,
    output logic [DATA_W-1:0]     b_col1,
    output logic [DATA_W-1:0]     b_col2,
    input  logic [9*ACC_W-1:0]    arr_c,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [9*ACC_W-1:0]    c_out,
    output logic                  busy
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_e               state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [DRN_W-1:0]     drain_q, drain_d;
    logic [9*ACC_W-1:0]   c_out_q, c_out_d;
    logic                 arr_rst_n_q, arr_rst_n_d;
    logic                 load;

    // Next-state, counters, operand load and result capture.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drain_d = drain_q;
        c_out_d = c_out_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    load    = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                k_d     = '0;
            end
            ST_FEED: begin
                if (k_q == K_W'(N - 1)) begin
                    state_d = ST_DRAIN;
                    k_d     = '0;
                    drain_d = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_W'(DRAIN_CYC - 1)) begin
                    state_d = ST_DONE;
                    drain_d = '0;
                    c_out_d = arr_c;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered so the clear pulse lines up with CLEAR and rises on the first edge after reset.
        arr_rst_n_d = (state_d != ST_CLEAR);
    end

    // State, counters, result and array-clear registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            drain_q     <= '0;
            c_out_q     <= '0;
            arr_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            c_out_q     <= c_out_d;
            arr_rst_n_q <= arr_rst_n_d;
        end
    end

    systolic_feeder #(
        .DATA_W (DATA_W)
    ) u_feeder (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .feed_en (state_q == ST_FEED),
        .k_idx   (k_q),
        .a_mat   (a_mat),
        .b_mat   (b_mat),
        .a_row0  (a_row0),
        .a_row1  (a_row1),
        .a_row2  (a_row2),
        .b_col0  (b_col0),
        .b_col1  (b_col1),
        .b_col2  (b_col2)
    );

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign c_out       = c_out_q;
    assign arr_rst_n   = arr_rst_n_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl with a simple accumulate-in-place 3x3 array model attached.
// Latency: checks the 12-cycle start-to-result timing at default parameters.
// Backpressure: exercises res_ready held low and start_valid held high.
module tb_systolic_ctrl;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start_valid = 1'b0;
    logic                start_ready;
    logic [9*DATA_W-1:0] a_mat = '0;
    logic [9*DATA_W-1:0] b_mat = '0;
    logic                arr_rst_n;
    logic [DATA_W-1:0]   a_row0, a_row1, a_row2;
    logic [DATA_W-1:0]   b_col0, b_col1, b_col2;
    logic [9*ACC_W-1:0]  arr_c;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [9*ACC_W-1:0]  c_out;
    logic                busy;

    int n_checks = 0;
    int n_errs   = 0;

    // Operand / result patterns (element 0 at the LSB).
    localparam logic [9*DATA_W-1:0] M_I   = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    localparam logic [9*DATA_W-1:0] M_2I  = {8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd2};
    localparam logic [9*DATA_W-1:0] M_SEQ = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [9*DATA_W-1:0] M_FF  = {9{8'hFF}};
    localparam logic [9*ACC_W-1:0]  C_SEQ = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [9*ACC_W-1:0]  C_2X  = {16'd18, 16'd16, 16'd14, 16'd12, 16'd10, 16'd8, 16'd6, 16'd4, 16'd2};
    localparam logic [9*ACC_W-1:0]  C_FF  = {9{16'd64003}};

    always #5 clk = ~clk;

    systolic_ctrl #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .DRAIN_CYC (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_mat       (a_mat),
        .b_mat       (b_mat),
        .arr_rst_n   (arr_rst_n),
        .a_row0      (a_row0),
        .a_row1      (a_row1),
        .a_row2      (a_row2),
        .b_col0      (b_col0),
        .b_col1      (b_col1),
        .b_col2      (b_col2),
        .arr_c       (arr_c),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .c_out       (c_out),
        .busy        (busy)
    );

    // Array model: each PE accumulates a_row[i]*b_col[j] per cycle, cleared by arr_rst_n.
    logic [DATA_W-1:0] a_r [3];
    logic [DATA_W-1:0] b_c [3];
    logic [ACC_W-1:0]  acc [9];

    assign a_r[0] = a_row0;
    assign a_r[1] = a_row1;
    assign a_r[2] = a_row2;
    assign b_c[0] = b_col0;
    assign b_c[1] = b_col1;
    assign b_c[2] = b_col2;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!arr_rst_n) acc[i*3+j] <= '0;
                else acc[i*3+j] <= acc[i*3+j] + ACC_W'(ACC_W'(a_r[i]) * ACC_W'(b_c[j]));
            end
        end
    end

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < 9; i++) arr_c[ACC_W*i +: ACC_W] = acc[i];
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for res_valid, then compare the captured result.
    task automatic wait_res(input string tag, input logic [9*ACC_W-1:0] exp_c);
        int n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_valid"}, res_valid, 1'b1);
        check({tag, "_c"}, c_out, exp_c);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_rv_low"}, res_valid, 1'b0);
        check({tag, "_idle"}, start_ready, 1'b1);
    endtask

    // Full job with exact latency check: result appears in the 12th cycle after acceptance.
    task automatic run_job(input string tag, input logic [9*DATA_W-1:0] a,
                           input logic [9*DATA_W-1:0] b, input logic [9*ACC_W-1:0] exp_c);
        a_mat = a;
        b_mat = b;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check({tag, "_early"}, res_valid, 1'b0);
        step();
        check({tag, "_lat"}, res_valid, 1'b1);
        check({tag, "_c"}, c_out, exp_c);
        handshake(tag);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", start_ready, 1'b1);
        check("rst_arr_n", arr_rst_n, 1'b0);
        check("rst_c", c_out, '0);
        check("rst_feeds", {a_row0, a_row1, a_row2, b_col0, b_col1, b_col2}, '0);
        step();
        rst = 1'b0;
        #1;
        check("rst_arr_n_hold", arr_rst_n, 1'b0);
        step();
        check("rst_arr_n_rise", arr_rst_n, 1'b1);

        // Identity x {1..9}: feed pattern, latency, then a 20-cycle stall on res_ready
        a_mat = M_I;
        b_mat = M_SEQ;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        check("clr_arr_n", arr_rst_n, 1'b0);
        check("clr_busy", busy, 1'b1);
        check("clr_ready", start_ready, 1'b0);
        check("clr_feed", a_row0, 8'd0);
        step();
        check("k0_arr_n", arr_rst_n, 1'b1);
        check("k0_feeds", {a_row0, a_row1, b_col0, b_col2}, {8'd1, 8'd0, 8'd1, 8'd3});
        step();
        check("k1_feeds", {a_row1, b_col0}, {8'd1, 8'd4});
        step();
        check("k2_feeds", {a_row2, b_col2}, {8'd1, 8'd9});
        step();
        check("drain_feeds", {a_row2, b_col2}, '0);
        check("drain_busy", busy, 1'b1);
        for (int c = 0; c < 6; c++) step();
        check("id_early", res_valid, 1'b0);
        step();
        check("id_lat", res_valid, 1'b1);
        check("id_c", c_out, C_SEQ);
        for (int c = 0; c < 20; c++) begin
            step();
            check("stall_valid", res_valid, 1'b1);
            check("stall_c", c_out, C_SEQ);
            check("stall_flags", {busy, start_ready}, 2'b10);
        end
        handshake("stall");
        check("stall_busy", busy, 1'b0);
        check("retain_c", c_out, C_SEQ);

        // Wrap-around: 3*255*255 mod 2^16
        run_job("ff", M_FF, M_FF, C_FF);

        // start_valid pulsed during FEED with different operands is ignored
        a_mat = M_I;
        b_mat = M_SEQ;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        a_mat = M_FF;
        b_mat = M_FF;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        check("ign_feed", a_row1, 8'd1);
        wait_res("ign", C_SEQ);
        handshake("ign");

        // Reset during FEED k=1 aborts the job; the next job shows no stale accumulation
        a_mat = M_FF;
        b_mat = M_FF;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        step();
        #1;
        rst = 1'b1;
        #1;
        check("abort_feeds", {a_row0, a_row1, a_row2, b_col0, b_col1, b_col2}, '0);
        check("abort_flags", {busy, res_valid, arr_rst_n}, 3'b000);
        check("abort_c", c_out, '0);
        step();
        rst = 1'b0;
        step();
        check("abort_arr_n", arr_rst_n, 1'b1);
        check("abort_nores", res_valid, 1'b0);
        run_job("post", M_2I, M_SEQ, C_2X);

        // Back-to-back with start_valid held high
        a_mat = M_I;
        b_mat = M_SEQ;
        start_valid = 1'b1;
        step();
        a_mat = M_2I;
        wait_res("b2b1", C_SEQ);
        check("b2b_done_ready", start_ready, 1'b0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("b2b_idle", start_ready, 1'b1);
        step();
        check("b2b_clr", {busy, arr_rst_n}, 2'b10);
        step();
        start_valid = 1'b0;
        check("b2b_feed", {arr_rst_n, a_row0}, {1'b1, 8'd2});
        wait_res("b2b2", C_2X);
        handshake("b2b2");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand element width.
REQ-002 SHALL have parameter ACC_W, default 16, accumulator/result element width.
REQ-003 SHALL have parameter DRAIN_CYC, default 7, cycles of zero-feed after last operand before result capture.
REQ-004 SHALL use one clock and asynchronous active-high reset: clk input 1 rising-edge clock; rst input 1 async active-high reset.
REQ-005 SHALL have start_valid input 1, job request.
REQ-006 SHALL have start_ready output 1, high only in IDLE.
REQ-007 SHALL have a_mat input 9*DATA_W, A[i][k] at bits DATA_W*(3i+k).
REQ-008 SHALL have b_mat input 9*DATA_W, B[k][j] at bits DATA_W*(3k+j).
REQ-009 SHALL have arr_rst_n output 1, active-low accumulator clear to the array.
REQ-010 SHALL have a_row0..a_row2 outputs DATA_W each, array row feeds.
REQ-011 SHALL have b_col0..b_col2 outputs DATA_W each, array column feeds.
REQ-012 SHALL have arr_c input 9*ACC_W, array results, C[i][j] at bits ACC_W*(3i+j).
REQ-013 SHALL have res_valid output 1, result-valid flag.
REQ-014 SHALL have res_ready input 1, consumer accept.
REQ-015 SHALL have c_out output 9*ACC_W, captured result, same packing as arr_c.
REQ-016 SHALL have busy output 1, high in any state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
REQ-018 SHALL accept a job when start_valid && start_ready, registering a_mat/b_mat into internal operand registers that cycle.
REQ-019 SHALL ignore start_valid in all states other than IDLE; later a_mat/b_mat changes SHALL NOT affect the running job.
REQ-020 SHALL drive arr_rst_n low for exactly one cycle in CLEAR; high in FEED, DRAIN, DONE and IDLE.
REQ-021 SHALL spend exactly 3 cycles in FEED, k=0,1,2: a_row_i = A[i][k], b_col_j = B[k][j]; row/column skew is supplied by the array.
REQ-022 SHALL drive all a_row/b_col outputs to zero in every state except FEED.
REQ-023 SHALL count DRAIN_CYC cycles in DRAIN, then capture arr_c into c_out and enter DONE with res_valid=1.
REQ-024 SHALL hold c_out and res_valid stable in DONE until res_ready=1, then return to IDLE with res_valid=0 next cycle.
REQ-025 SHALL give a latency from start acceptance edge to first res_valid=1 cycle of 5+DRAIN_CYC cycles (12 at default).
REQ-026 SHALL retain c_out after handshake until the next capture.
REQ-027 SHALL pass results through unmodified; the array's ACC_W wrap-around on overflow is visible in c_out.
REQ-028 SHALL accept start_valid held high in DONE only after returning to IDLE (no same-cycle DONE->CLEAR).

Reset
REQ-029 SHALL, on rst high at any time, immediately force IDLE, clear all counters, and drive res_valid=0, busy=0, c_out=0, all feeds=0, and arr_rst_n=0.
REQ-030 SHALL drive arr_rst_n=1 beginning the first clock edge after rst deasserts; an aborted job SHALL produce no result.

Structure
REQ-031 SHALL place the FSM state enum, the array dimension constant N=3, and the packing index helpers in shared package systolic_pkg.
REQ-032 SHALL keep the FSM, FEED index counter and DRAIN counter in this module; the operand register/row-column mux SHALL be sub-module systolic_feeder.

Verification
REQ-033 SHALL verify A=identity, B={1..9} row-major, array attached -> after 12 cycles res_valid=1, c_out={1,2,3,4,5,6,7,8,9}.
REQ-034 SHALL verify A=B=all 255 -> every C element = 195075 mod 65536 = 64003.
REQ-035 SHALL verify res_ready held low 20 cycles after res_valid -> c_out and res_valid stable, busy=1, start_ready=0; then res_ready=1 -> IDLE next cycle.
REQ-036 SHALL verify start_valid pulsed during FEED with different a_mat -> ignored; the result matches the first job.
REQ-037 SHALL verify rst asserted during FEED k=1 -> outputs zero immediately; the next job with A=2*I, B={1..9} -> c_out={2,4,...,18}, with no stale accumulation.
REQ-038 SHALL verify back-to-back jobs with start_valid held high -> the second job is accepted in the first IDLE cycle after the handshake, and the arr_rst_n pulse precedes its FEED.
